// File: rtl/if_stage_if.sv
// Bundle of the fetch stage's external signals: the shared byte-wide memory
// port toward the arbiter, the control inputs from later pipeline stages, and
// the instruction presented to the IF/ID register.
//
//   stall          : IF/ID cannot accept this cycle
//   branch_flag    : redirect request from a later stage
//   branch_target  : redirect PC (low two bits ignored)
//   mem_grant      : arbiter grants the memory port this cycle
//   mem_rdata      : byte for the granted request of the previous cycle
//   mem_rd_en      : byte read request
//   mem_addr       : byte address of the request
//   if_pc          : PC of the presented instruction
//   if_inst        : assembled instruction
//   if_valid       : if_pc / if_inst valid
//
// master = fetch stage side, slave = environment (arbiter + pipeline) side.
interface if_stage_if;
    logic        stall;
    logic        branch_flag;
    logic [31:0] branch_target;
    logic        mem_grant;
    logic [7:0]  mem_rdata;
    logic        mem_rd_en;
    logic [31:0] mem_addr;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        if_valid;

    modport master (
        input  stall, branch_flag, branch_target, mem_grant, mem_rdata,
        output mem_rd_en, mem_addr, if_pc, if_inst, if_valid
    );

    modport slave (
        output stall, branch_flag, branch_target, mem_grant, mem_rdata,
        input  mem_rd_en, mem_addr, if_pc, if_inst, if_valid
    );
endinterface

// File: rtl/if_stage.sv
// RV32I instruction-fetch stage. Keeps the program counter, fetches the four
// bytes of one instruction over the shared 8-bit memory port, assembles them
// little-endian and presents the word with its PC to IF/ID. Stalls hold the
// presented instruction; a redirect from a later stage restarts fetch at the
// branch target and discards anything in flight.
//
// Ports:
//   clk  : pipeline clock, rising edge
//   rst  : asynchronous reset, active low
//   bus  : if_stage_if.master (memory port, stall/redirect, IF/ID outputs)
//
// States:
//   FETCH | issuing byte requests / capturing returned bytes
//   HOLD  | instruction presented, waiting for IF/ID to accept it
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic       clk,
    input  logic       rst,
    if_stage_if.master bus
);

    typedef enum logic {
        FETCH = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic [2:0]  issued;
    logic [2:0]  recvd;
    logic        pending;
    logic [23:0] byte_buf;
    logic [31:0] if_pc_q;
    logic [31:0] if_inst_q;
    logic        if_valid_q;
    logic        grant_issue;

    // Request gated by rst so nothing is asked for while reset is held.
    assign bus.mem_rd_en = rst && (state == FETCH) && (issued < 3'd4) && !bus.branch_flag;
    assign bus.mem_addr  = pc + {29'd0, issued};
    assign grant_issue   = bus.mem_rd_en && bus.mem_grant;

    assign bus.if_pc    = if_pc_q;
    assign bus.if_inst  = if_inst_q;
    assign bus.if_valid = if_valid_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= FETCH;
            pc         <= RESET_PC;
            issued     <= 3'd0;
            recvd      <= 3'd0;
            pending    <= 1'b0;
            byte_buf   <= 24'd0;
            if_pc_q    <= 32'd0;
            if_inst_q  <= 32'd0;
            if_valid_q <= 1'b0;
        end else if (bus.branch_flag) begin
            // Redirect beats consume and capture; the byte on mem_rdata now
            // belongs to the abandoned fetch and is dropped.
            state      <= FETCH;
            pc         <= {bus.branch_target[31:2], 2'b00};
            issued     <= 3'd0;
            recvd      <= 3'd0;
            pending    <= 1'b0;
            if_valid_q <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    pending <= grant_issue;
                    if (grant_issue) begin
                        issued <= issued + 3'd1;
                    end
                    if (pending) begin
                        recvd <= recvd + 3'd1;
                        case (recvd[1:0])
                            2'd0: byte_buf[7:0]   <= bus.mem_rdata;
                            2'd1: byte_buf[15:8]  <= bus.mem_rdata;
                            2'd2: byte_buf[23:16] <= bus.mem_rdata;
                            default: begin
                                if_inst_q  <= {bus.mem_rdata, byte_buf};
                                if_pc_q    <= pc;
                                if_valid_q <= 1'b1;
                                state      <= HOLD;
                            end
                        endcase
                    end
                end
                HOLD: begin
                    if (!bus.stall) begin
                        pc         <= pc + 32'd4;
                        issued     <= 3'd0;
                        recvd      <= 3'd0;
                        pending    <= 1'b0;
                        if_valid_q <= 1'b0;
                        state      <= FETCH;
                    end
                end
                default: state <= FETCH;
            endcase
        end
    end

endmodule
